// File: rtl/dec_onehot_pipe_if.sv
// ---------------------------------------------------------------------------
// dec_onehot_pipe_if
// Purpose : bundles the upstream (index in) and downstream (mask out)
//           valid/ready channels of the pipelined decoder.
// Signals :
//   in_valid  - upstream transaction valid
//   in_ready  - decoder can accept a transaction this cycle
//   in_data   - IN_W-bit binary index
//   in_mode   - 0 = one-hot, 1 = thermometer
//   out_valid - decoded mask valid
//   out_ready - downstream accepts the mask this cycle
//   out_data  - OUT_W-bit decoded mask
//   out_err   - index was out of range (only with DEC_RANGE_ERR_EN)
// Modports: master = the side that supplies indices and consumes masks,
//           slave  = the decoder itself.
// ---------------------------------------------------------------------------
interface dec_onehot_pipe_if #(
   parameter int IN_W  = 6,
   parameter int OUT_W = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/dec_onehot_pipe.sv
// ---------------------------------------------------------------------------
// dec_onehot_pipe
// Purpose : two-stage elastic binary decoder. An IN_W-bit index becomes an
//           OUT_W-bit one-hot or thermometer mask. Stage 1 splits the index
//           into a high group (one-hot + "below" mask) and a low group
//           (one-hot or thermometer); stage 2 combines them into the mask.
// Ports   :
//   clk_i   - clock, rising edge
//   rst_n_i - synchronous reset, active low
//   bus     - dec_onehot_pipe_if.slave (valid/ready in, valid/ready out)
// Parameters: IN_W (2..10), OUT_W (2..2**IN_W), LO_W (1..IN_W-1)
// Optional  : define DEC_RANGE_ERR_EN to pipeline an out-of-range flag onto
//             bus.out_err; otherwise out_err is tied low.
// ---------------------------------------------------------------------------
module dec_onehot_pipe #(
   parameter int IN_W  = 6,
   parameter int OUT_W = 64,
   parameter int LO_W  = 3
) (
   input logic              clk_i,
   input logic              rst_n_i,
   dec_onehot_pipe_if.slave bus
);
   localparam int HI_W = IN_W - LO_W;
   localparam int NG   = 1 << HI_W;
   localparam int NL   = 1 << LO_W;

   logic [HI_W-1:0]  hi_idx;
   logic [LO_W-1:0]  lo_idx;
   logic [NG-1:0]    hi_oh_d;
   logic [NG-1:0]    hi_below_d;
   logic [NL-1:0]    lo_d;

   logic [NG-1:0]    hi_oh_q;
   logic [NG-1:0]    hi_below_q;
   logic [NL-1:0]    lo_q;
   logic             mode_q;
   logic             s1_v;

   logic [OUT_W-1:0] mask_d;
   logic [OUT_W-1:0] data_q;
   logic             valid_q;

   logic             s2_load;
   logic             in_fire;

   assign hi_idx = bus.in_data[IN_W-1:LO_W];
   assign lo_idx = bus.in_data[LO_W-1:0];

   // Stage 1 decode of the incoming index into group and lane masks
   always_comb begin
      hi_oh_d    = '0;
      hi_below_d = '0;
      lo_d       = '0;
      for (int g = 0; g < NG; g++) begin
         hi_oh_d[g]    = (hi_idx == HI_W'(g));
         hi_below_d[g] = (HI_W'(g) < hi_idx);
      end
      for (int k = 0; k < NL; k++) begin
         lo_d[k] = bus.in_mode ? (LO_W'(k) <= lo_idx) : (LO_W'(k) == lo_idx);
      end
   end

   // Stage 2 combine; lanes beyond OUT_W are simply never built, which
   // gives zero for one-hot and saturation for thermometer out-of-range
   always_comb begin
      mask_d = '0;
      for (int b = 0; b < OUT_W; b++) begin
         mask_d[b] = hi_oh_q[b / NL] & lo_q[b % NL];
         if (mode_q) begin
            mask_d[b] = mask_d[b] | hi_below_q[b / NL];
         end
      end
   end

   // S1 may hand off to S2 whenever S2 is empty or being drained, and can
   // refill in the same cycle, so a full-rate stream never sees a bubble
   assign s2_load      = s1_v & (~valid_q | bus.out_ready);
   assign bus.in_ready = ~s1_v | s2_load;
   assign in_fire      = bus.in_valid & bus.in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;

   // Pipeline registers for both stages
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1_v       <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         hi_oh_q    <= '0;
         hi_below_q <= '0;
         lo_q       <= '0;
         mode_q     <= 1'b0;
      end else begin
         if (in_fire) begin
            hi_oh_q    <= hi_oh_d;
            hi_below_q <= hi_below_d;
            lo_q       <= lo_d;
            mode_q     <= bus.in_mode;
            s1_v       <= 1'b1;
         end else if (s2_load) begin
            s1_v <= 1'b0;
         end

         if (s2_load) begin
            data_q  <= mask_d;
            valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef DEC_RANGE_ERR_EN
   logic range_d;
   logic range_q;
   logic err_q;

   // Widened compare so OUT_W == 2**IN_W never flags an error
   assign range_d     = ({1'b0, bus.in_data} >= (IN_W+1)'(OUT_W));
   assign bus.out_err = err_q;

   // Range flag travels with its transaction through both stages
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         range_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (in_fire) begin
            range_q <= range_d;
         end
         if (s2_load) begin
            err_q <= range_q;
         end
      end
   end
`else
   assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_dec_onehot_pipe.sv
// ---------------------------------------------------------------------------
// tb_dec_onehot_pipe
// Purpose : drives two decoder instances in lock-step (6->64 with LO_W=3 and
//           6->40 with LO_W=2) from one stimulus stream and checks their
//           masks against a reference computed straight from the definition
//           of one-hot / thermometer masks. Honours DEC_RANGE_ERR_EN.
// ---------------------------------------------------------------------------
module tb_dec_onehot_pipe;
   localparam int IN_W = 6;
`ifdef DEC_RANGE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          cyc;
   } rec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            valid = 1'b0;
   logic            mode = 1'b0;
   logic            rdy = 1'b1;
   logic [IN_W-1:0] idx = '0;

   rec_t exp_q[2][$];
   rec_t obs_q[2][$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   last_acc = 1'b0;

   always #5 clk = ~clk;

   dec_onehot_pipe_if #(.IN_W(IN_W), .OUT_W(64)) bus_a ();
   dec_onehot_pipe_if #(.IN_W(IN_W), .OUT_W(40)) bus_b ();

   assign bus_a.in_valid  = valid;
   assign bus_a.in_data   = idx;
   assign bus_a.in_mode   = mode;
   assign bus_a.out_ready = rdy;
   assign bus_b.in_valid  = valid;
   assign bus_b.in_data   = idx;
   assign bus_b.in_mode   = mode;
   assign bus_b.out_ready = rdy;

   dec_onehot_pipe #(.IN_W(IN_W), .OUT_W(64), .LO_W(3)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus_a));
   dec_onehot_pipe #(.IN_W(IN_W), .OUT_W(40), .LO_W(2)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus_b));

   // Reference mask: bit b set when b == i (one-hot) or b <= i (thermometer)
   function automatic rec_t model(int i, bit m, int ow);
      rec_t r;
      r.data = '0;
      for (int b = 0; b < ow; b++) r.data[b] = m ? (b <= i) : (b == i);
      r.err = ERR_EN && (i >= ow);
      r.cyc = 0;
      return r;
   endfunction

   // Records the handshakes of the coming edge, then advances one cycle
   task automatic tick();
      rec_t r;
      #1;
      last_acc = valid && bus_a.in_ready;
      if (rst_n) begin
         if (bus_a.out_valid && rdy) begin
            r.data = bus_a.out_data; r.err = bus_a.out_err; r.cyc = cyc;
            obs_q[0].push_back(r);
         end
         if (bus_b.out_valid && rdy) begin
            r.data = {24'b0, bus_b.out_data}; r.err = bus_b.out_err; r.cyc = cyc;
            obs_q[1].push_back(r);
         end
         if (valid && bus_a.in_ready) begin
            r = model(int'(idx), mode, 64); r.cyc = cyc;
            exp_q[0].push_back(r);
         end
         if (valid && bus_b.in_ready) begin
            r = model(int'(idx), mode, 40); r.cyc = cyc;
            exp_q[1].push_back(r);
         end
      end else begin
         for (int d = 0; d < 2; d++)
            while (exp_q[d].size() > obs_q[d].size()) void'(exp_q[d].pop_back());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input int i, input bit m);
      int n = 0;
      valid = 1'b1; idx = IN_W'(i); mode = m;
      do begin tick(); n++; end while (!last_acc && n < 30);
      if (!last_acc) begin
         total++; bad++;
         $display("[TB] FAIL accept_timeout idx=%0d: got no accept want accept", i);
      end
   endtask

   task automatic drain();
      int n = 0;
      valid = 1'b0;
      while ((obs_q[0].size() < exp_q[0].size() || obs_q[1].size() < exp_q[1].size()) && n < 50) begin
         tick(); n++;
      end
      repeat (3) tick();
      if (n >= 50) begin
         total++; bad++;
         $display("[TB] FAIL drain_timeout: got %0d/%0d outputs want %0d/%0d",
                  obs_q[0].size(), obs_q[1].size(), exp_q[0].size(), exp_q[1].size());
      end
   endtask

   task automatic clear_q();
      for (int d = 0; d < 2; d++) begin exp_q[d].delete(); obs_q[d].delete(); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b1; rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         idx = IN_W'($urandom_range(0, 63)); mode = 1'($urandom);
         tick();
         total++;
         if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 64'h0 || bus_a.out_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_a: got v=%b d=%h e=%b want v=0 d=0 e=0",
                     bus_a.out_valid, bus_a.out_data, bus_a.out_err);
         end
         total++;
         if (bus_b.out_valid !== 1'b0 || bus_b.out_data !== 40'h0 || bus_b.out_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_b: got v=%b d=%h e=%b want v=0 d=0 e=0",
                     bus_b.out_valid, bus_b.out_data, bus_b.out_err);
         end
      end
      rst_n = 1'b1; valid = 1'b0;
      #1;
      total++;
      if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_ready: got %b/%b want 1/1", bus_a.in_ready, bus_b.in_ready);
      end
      tick();
      clear_q();
   endtask

   task automatic test_stream_onehot();
      logic [63:0] ea[3] = '{64'h1, 64'h200, 64'h8000_0000_0000_0000};
      logic [63:0] eb[3] = '{64'h1, 64'h200, 64'h0};
      logic        eb_err[3] = '{1'b0, 1'b0, ERR_EN};
      int          ids[3] = '{0, 9, 63};
      clear_q(); rdy = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(ids[i], 1'b0);
      drain();
      total++;
      if (obs_q[0].size() != 3 || obs_q[1].size() != 3 || exp_q[0].size() != 3) begin
         bad++;
         $display("[TB] FAIL stream_count: got %0d/%0d want 3/3", obs_q[0].size(), obs_q[1].size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_q[0][i].data !== ea[i] || obs_q[0][i].err !== 1'b0) begin
               bad++;
               $display("[TB] FAIL stream_a[%0d]: got %h/%b want %h/0", i, obs_q[0][i].data, obs_q[0][i].err, ea[i]);
            end
            total++;
            if (obs_q[1][i].data !== eb[i] || obs_q[1][i].err !== eb_err[i]) begin
               bad++;
               $display("[TB] FAIL stream_b[%0d]: got %h/%b want %h/%b", i, obs_q[1][i].data, obs_q[1][i].err, eb[i], eb_err[i]);
            end
            total++;
            if (obs_q[0][i].cyc - exp_q[0][i].cyc != 2) begin
               bad++;
               $display("[TB] FAIL latency[%0d]: got %0d want 2", i, obs_q[0][i].cyc - exp_q[0][i].cyc);
            end
         end
      end
   endtask

   task automatic test_thermo();
      logic [63:0] ea[3] = '{64'h3FF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [63:0] eb[3] = '{64'h3FF, 64'h1, 64'hFF_FFFF_FFFF};
      logic        eb_err[3] = '{1'b0, 1'b0, ERR_EN};
      int          ids[3] = '{9, 0, 63};
      clear_q(); rdy = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(ids[i], 1'b1);
      drain();
      total++;
      if (obs_q[0].size() != 3 || obs_q[1].size() != 3) begin
         bad++;
         $display("[TB] FAIL thermo_count: got %0d/%0d want 3/3", obs_q[0].size(), obs_q[1].size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_q[0][i].data !== ea[i] || obs_q[0][i].err !== 1'b0) begin
               bad++;
               $display("[TB] FAIL thermo_a[%0d]: got %h/%b want %h/0", i, obs_q[0][i].data, obs_q[0][i].err, ea[i]);
            end
            total++;
            if (obs_q[1][i].data !== eb[i] || obs_q[1][i].err !== eb_err[i]) begin
               bad++;
               $display("[TB] FAIL thermo_b[%0d]: got %h/%b want %h/%b", i, obs_q[1][i].data, obs_q[1][i].err, eb[i], eb_err[i]);
            end
         end
      end
   endtask

   task automatic test_truncation();
      clear_q(); rdy = 1'b1;
      applyStimulus(45, 1'b0);
      applyStimulus(45, 1'b1);
      drain();
      total++;
      if (obs_q[0].size() != 2 || obs_q[1].size() != 2) begin
         bad++;
         $display("[TB] FAIL trunc_count: got %0d/%0d want 2/2", obs_q[0].size(), obs_q[1].size());
      end else begin
         total++;
         if (obs_q[1][0].data !== 64'h0 || obs_q[1][0].err !== ERR_EN) begin
            bad++;
            $display("[TB] FAIL trunc_onehot: got %h/%b want 0/%b", obs_q[1][0].data, obs_q[1][0].err, ERR_EN);
         end
         total++;
         if (obs_q[1][1].data !== 64'hFF_FFFF_FFFF || obs_q[1][1].err !== ERR_EN) begin
            bad++;
            $display("[TB] FAIL trunc_thermo: got %h/%b want ffffffffff/%b", obs_q[1][1].data, obs_q[1][1].err, ERR_EN);
         end
         total++;
         if (obs_q[0][0].data !== 64'h0000_2000_0000_0000 || obs_q[0][1].data !== 64'h0000_3FFF_FFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL idx45_a: got %h,%h want 0000200000000000,00003fffffffffff", obs_q[0][0].data, obs_q[0][1].data);
         end
      end
   endtask

   task automatic test_backpressure();
      rec_t first;
      clear_q();
      rdy = 1'b1;
      valid = 1'b1; idx = 6'd17; mode = 1'b0;
      tick();
      rdy = 1'b0; idx = 6'd42; mode = 1'b1;
      tick();
      idx = 6'd5; mode = 1'b0;
      #1;
      total++;
      if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_full: got ready %b/%b want 0/0", bus_a.in_ready, bus_b.in_ready);
      end
      first = model(17, 1'b0, 64);
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== first.data) begin
            bad++;
            $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=%h", c, bus_a.out_valid, bus_a.out_data, first.data);
         end
      end
      rdy = 1'b1;
      applyStimulus(5, 1'b0);
      drain();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (obs_q[d].size() != 3 || exp_q[d].size() != 3) begin
            bad++;
            $display("[TB] FAIL bp_count dut%0d: got %0d want 3 (accepted %0d)", d, obs_q[d].size(), exp_q[d].size());
         end else begin
            for (int i = 0; i < 3; i++) begin
               total++;
               if (obs_q[d][i].data !== exp_q[d][i].data || obs_q[d][i].err !== exp_q[d][i].err) begin
                  bad++;
                  $display("[TB] FAIL bp_order dut%0d[%0d]: got %h/%b want %h/%b", d, i,
                           obs_q[d][i].data, obs_q[d][i].err, exp_q[d][i].data, exp_q[d][i].err);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      clear_q();
      rdy = 1'b0;
      applyStimulus(5, 1'b0);
      applyStimulus(50, 1'b1);
      valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_valid: got %b/%b want 0/0", bus_a.out_valid, bus_b.out_valid);
      end
      rdy = 1'b1;
      repeat (6) tick();
      total++;
      if (obs_q[0].size() != 0 || obs_q[1].size() != 0) begin
         bad++;
         $display("[TB] FAIL midreset_stale: got %0d/%0d outputs want 0/0", obs_q[0].size(), obs_q[1].size());
      end
   endtask

   task automatic test_random();
      clear_q();
      valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!valid || last_acc) begin
            valid = ($urandom_range(0, 3) != 0);
            idx   = IN_W'($urandom_range(0, 63));
            mode  = 1'($urandom);
         end
         rdy = ($urandom_range(0, 3) != 0);
         tick();
      end
      rdy = 1'b1;
      drain();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (obs_q[d].size() != exp_q[d].size()) begin
            bad++;
            $display("[TB] FAIL rnd_count dut%0d: got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
         end else begin
            for (int i = 0; i < obs_q[d].size(); i++) begin
               total++;
               if (obs_q[d][i].data !== exp_q[d][i].data || obs_q[d][i].err !== exp_q[d][i].err) begin
                  bad++;
                  $display("[TB] FAIL rnd dut%0d[%0d]: got %h/%b want %h/%b", d, i,
                           obs_q[d][i].data, obs_q[d][i].err, exp_q[d][i].data, exp_q[d][i].err);
               end
            end
         end
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_stream_onehot();
      test_thermo();
      test_truncation();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
